pv1000_psg: RTL and testbench



---
 rtl/pv1000_snd_pkg.sv | 31 +++
 rtl/pv1000_psg_tone.sv | 47 ++++
 rtl/pv1000_psg.sv | 133 +++++++++++++
 tb/tb_pv1000_psg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pv1000_snd_pkg.sv
// Shared constants and small helpers for the PV-1000 sound block.
package pv1000_snd_pkg;

  // A period of 3Fh mutes a channel; the counter limit is 3Eh minus the period.
  localparam logic [5:0] PSG_PERIOD_MUTE = 6'h3F;
  localparam logic [5:0] PSG_LIMIT_BASE  = 6'h3E;

  // Register select values carried on wr_addr (CPU ports F8h..FBh).
  localparam logic [1:0] PSG_ADDR_CH0  = 2'd0;
  localparam logic [1:0] PSG_ADDR_CH1  = 2'd1;
  localparam logic [1:0] PSG_ADDR_CH2  = 2'd2;
  localparam logic [1:0] PSG_ADDR_CTRL = 2'd3;

  // Control register bit positions.
  localparam int CTRL_ENABLE = 1;
  localparam int CTRL_RING   = 0;

  // Control register value after reset: enabled, normal (non-ring) mode.
  localparam logic [1:0] PSG_CTRL_RESET = 2'b10;

  // Terminal count for a channel; wraps modulo 64 like the original hardware.
  function automatic logic [5:0] psg_limit(input logic [5:0] period);
    return PSG_LIMIT_BASE - period;
  endfunction

  // Number of channels currently high.
  function automatic logic [1:0] psg_popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/pv1000_psg_tone.sv
// One square-wave channel: period register, tick counter and square flop.
module pv1000_psg_tone (
  input  logic       clk_snd,
  input  logic       reset,
  input  logic       tick,
  input  logic       wr_stb,
  input  logic [5:0] wr_data,
  output logic       sq
);
  import pv1000_snd_pkg::*;

  logic [5:0] period;
  logic [5:0] cnt;
  logic [5:0] limit;
  logic       muted;

  assign limit = psg_limit(period);
  assign muted = (period == PSG_PERIOD_MUTE);

  // Period register; a write never disturbs the running counter.
  always_ff @(posedge clk_snd) begin
    if (reset) begin
      period <= PSG_PERIOD_MUTE;
    end else if (wr_stb) begin
      period <= wr_data;
    end
  end

  // Counter and square; >= compare lets a shortened period take effect on the next tick.
  always_ff @(posedge clk_snd) begin
    if (reset) begin
      cnt <= 6'd0;
      sq  <= 1'b0;
    end else if (muted) begin
      cnt <= 6'd0;
      sq  <= 1'b0;
    end else if (tick) begin
      if (cnt >= limit) begin
        cnt <= 6'd0;
        sq  <= ~sq;
      end else begin
        cnt <= cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/pv1000_psg.sv
// PV-1000 three-channel square-wave PSG: write handshake from the system
// clock domain, tone prescaler, control register, ring XOR and mixer.
module pv1000_psg #(
  parameter int PRESCALE = 512,
  parameter int VOL_STEP = 64
) (
  input  logic       clk_snd,
  input  logic       reset,
  input  logic       wr_toggle,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] audio,
  output logic [2:0] tone
);
  import pv1000_snd_pkg::*;

  localparam int                PRE_W    = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

  // Output level for the current tone bits; 3*VOL_STEP fits in 8 bits.
  function automatic logic [7:0] mix_level(input logic [2:0] t, input logic en);
    logic [7:0] n;
    n = {6'd0, psg_popcount3(t)};
    return en ? n * 8'(VOL_STEP) : 8'd0;
  endfunction

  logic             tog_p0;
  logic             tog_p1;
  logic             tog_p2;
  logic             wr_stb;
  logic             stb_p3;
  logic [1:0]       addr_p3;
  logic [5:0]       data_p3;
  logic [2:0]       ch_wr;
  logic             ctrl_wr;
  logic [1:0]       ctrl;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [2:0]       sq;
  logic             unused_data_hi;

  // Upper data bits have no storage in any register.
  assign unused_data_hi = ^wr_data[7:6];

  // Stages p0/p1 synchronize wr_toggle; p2 is the delayed copy for edge detection.
  always_ff @(posedge clk_snd) begin
    if (reset) begin
      tog_p0 <= 1'b0;
      tog_p1 <= 1'b0;
      tog_p2 <= 1'b0;
    end else begin
      tog_p0 <= wr_toggle;
      tog_p1 <= tog_p0;
      tog_p2 <= tog_p1;
    end
  end

  assign wr_stb = tog_p1 ^ tog_p2;

  // Stage p3: capture the write while wr_addr/wr_data are guaranteed stable.
  always_ff @(posedge clk_snd) begin
    if (reset) begin
      stb_p3  <= 1'b0;
      addr_p3 <= 2'd0;
      data_p3 <= 6'd0;
    end else begin
      stb_p3 <= wr_stb;
      if (wr_stb) begin
        addr_p3 <= wr_addr;
        data_p3 <= wr_data[5:0];
      end
    end
  end

  // Decode the captured write into per-register strobes.
  always_comb begin
    ch_wr[0] = stb_p3 && (addr_p3 == PSG_ADDR_CH0);
    ch_wr[1] = stb_p3 && (addr_p3 == PSG_ADDR_CH1);
    ch_wr[2] = stb_p3 && (addr_p3 == PSG_ADDR_CH2);
    ctrl_wr  = stb_p3 && (addr_p3 == PSG_ADDR_CTRL);
  end

  // Control register: ENABLE and RING.
  always_ff @(posedge clk_snd) begin
    if (reset) begin
      ctrl <= PSG_CTRL_RESET;
    end else if (ctrl_wr) begin
      ctrl <= data_p3[1:0];
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: one tone tick every PRESCALE sound clocks.
  always_ff @(posedge clk_snd) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar n = 0; n < 3; n++) begin : g_ch
    pv1000_psg_tone u_tone (
      .clk_snd (clk_snd),
      .reset   (reset),
      .tick    (tick),
      .wr_stb  (ch_wr[n]),
      .wr_data (data_p3),
      .sq      (sq[n])
    );
  end

  // Ring mode XORs each channel with its neighbour.
  always_comb begin
    tone = sq;
    if (ctrl[CTRL_RING]) begin
      tone = {sq[2] ^ sq[0], sq[1] ^ sq[2], sq[0] ^ sq[1]};
    end
  end

  // Registered mixer; lags tone by one cycle.
  always_ff @(posedge clk_snd) begin
    if (reset) begin
      audio <= 8'd0;
    end else begin
      audio <= mix_level(tone, ctrl[CTRL_ENABLE]);
    end
  end

endmodule

// File: tb/tb_pv1000_psg.sv
// Scoreboard bench for pv1000_psg with a fast prescaler.
module tb_pv1000_psg;
  import pv1000_snd_pkg::*;

  localparam int PRESCALE = 4;
  localparam int VOL      = 64;
  localparam int IDLE     = 32'h3fff_ffff;

  logic       clk_snd   = 1'b0;
  logic       reset     = 1'b1;
  logic       wr_toggle = 1'b0;
  logic [1:0] wr_addr   = 2'd0;
  logic [7:0] wr_data   = 8'd0;
  logic [7:0] audio;
  logic [2:0] tone;

  pv1000_psg #(.PRESCALE(PRESCALE), .VOL_STEP(VOL)) dut (
    .clk_snd   (clk_snd),
    .reset     (reset),
    .wr_toggle (wr_toggle),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .audio     (audio),
    .tone      (tone)
  );

  always #5 clk_snd = ~clk_snd;

  int cyc = 0;
  always @(posedge clk_snd) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] tone;
    logic [7:0] audio;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Expected waveform description: each square toggles at edge first,
  // then every half*PRESCALE edges, starting from level init.
  int       m_first[3];
  int       m_half[3];
  bit       m_init[3];
  int       m_cl;
  bit [1:0] m_cb;
  bit [1:0] m_ca;

  function automatic bit sqv(int n, int e);
    if (e < m_first[n]) return m_init[n];
    return m_init[n] ^ ((((e - m_first[n]) / (PRESCALE * m_half[n])) % 2) == 0);
  endfunction

  function automatic bit [1:0] ctrl_at(int e);
    return (e >= m_cl) ? m_ca : m_cb;
  endfunction

  function automatic bit [2:0] tone_at(int e);
    bit [2:0] s;
    bit [1:0] c;
    s = {sqv(2, e), sqv(1, e), sqv(0, e)};
    c = ctrl_at(e);
    if (c[0]) return {s[2] ^ s[0], s[1] ^ s[2], s[0] ^ s[1]};
    return s;
  endfunction

  function automatic bit [7:0] audio_at(int e);
    bit [2:0] t;
    bit [1:0] c;
    int       k;
    t = tone_at(e - 1);
    c = ctrl_at(e - 1);
    k = int'(t[0]) + int'(t[1]) + int'(t[2]);
    if (!c[1]) return 8'd0;
    return 8'(k * VOL);
  endfunction

  task automatic push_window(input int a, input int b, input string name);
    exp_t x;
    for (int e = a; e <= b; e++) begin
      x.cyc   = e;
      x.tone  = tone_at(e);
      x.audio = audio_at(e);
      x.name  = name;
      sb.push_back(x);
    end
  endtask

  task automatic set_idle();
    for (int n = 0; n < 3; n++) begin
      m_first[n] = IDLE;
      m_half[n]  = 1;
      m_init[n]  = 1'b0;
    end
    m_cl = 0;
    m_cb = 2'b10;
    m_ca = 2'b10;
  endtask

  task automatic set_ch(input int n, input int first, input int half, input bit init);
    m_first[n] = first;
    m_half[n]  = half;
    m_init[n]  = init;
  endtask

  task automatic wait_cyc(input int e);
    while (cyc < e) @(negedge clk_snd);
  endtask

  // Returns the last edge that sampled reset high; ticks then land on n+4k.
  task automatic do_reset(output int n);
    @(negedge clk_snd);
    reset     = 1'b1;
    wr_toggle = 1'b0;
    repeat (2) @(negedge clk_snd);
    reset = 1'b0;
    n     = cyc;
  endtask

  // Issued on a falling edge; the register holds the value after edge cyc+4.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    wr_addr   = a;
    wr_data   = d;
    wr_toggle = ~wr_toggle;
  endtask

  // Monitor: compare every due scoreboard entry against the DUT outputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_snd);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front();
        n_total++;
        if (x.cyc == cyc && tone === x.tone && audio === x.audio) begin
          n_pass++;
        end else begin
          $display("FAIL %s cyc=%0d: tone=%b audio=%0d, expected tone=%b audio=%0d (due cyc %0d)",
                   x.name, cyc, tone, audio, x.tone, x.audio, x.cyc);
        end
      end
    end
  end

  initial begin
    int n;
    int n2;
    int w;
    bit i0;

    // Idle after reset: all channels muted.
    set_idle();
    do_reset(n);
    push_window(n + 1, n + 10000, "idle");
    wait_cyc(n + 10001);

    // ch0 = 3Eh (upper bits ignored): toggles every tick, audio 0/64 one cycle behind.
    set_idle();
    do_reset(n);
    set_ch(0, n + 12, 1, 1'b0);
    push_window(n + 1, n + 80, "single_3e");
    wait_cyc(n + 4);  do_write(PSG_ADDR_CH0, 8'hFE);
    wait_cyc(n + 81);

    // ch0 = 3Ch (3 ticks), ch1 = 3Eh (1 tick), ch2 stays muted.
    set_idle();
    do_reset(n);
    set_ch(0, n + 20, 3, 1'b0);
    set_ch(1, n + 16, 1, 1'b0);
    push_window(n + 1, n + 120, "three_ch");
    wait_cyc(n + 4);  do_write(PSG_ADDR_CH0, 8'h3C);
    wait_cyc(n + 8);  do_write(PSG_ADDR_CH1, 8'h3E);
    wait_cyc(n + 12); do_write(PSG_ADDR_CH2, 8'h3F);
    wait_cyc(n + 121);

    // ch0 = 00h, then 3Ah while the counter sits at 40: toggle on next tick, then 5 ticks.
    set_idle();
    do_reset(n);
    set_ch(0, n + 172, 5, 1'b0);
    push_window(n + 1, n + 252, "reload");
    wait_cyc(n + 4);   do_write(PSG_ADDR_CH0, 8'h00);
    wait_cyc(n + 166); do_write(PSG_ADDR_CH0, 8'h3A);
    wait_cyc(n + 253);

    // Ring mode with ch0/ch1 running, then ring with mixer disabled.
    set_idle();
    do_reset(n);
    set_ch(0, n + 12, 1, 1'b0);
    set_ch(1, n + 24, 3, 1'b0);
    m_cl = n + 44; m_cb = 2'b10; m_ca = 2'b11;
    push_window(n + 1, n + 80, "ring_on");
    m_cl = n + 84; m_cb = 2'b11; m_ca = 2'b01;
    push_window(n + 81, n + 160, "ring_mute");
    wait_cyc(n + 4);  do_write(PSG_ADDR_CH0, 8'h3E);
    wait_cyc(n + 8);  do_write(PSG_ADDR_CH1, 8'h3C);
    wait_cyc(n + 40); do_write(PSG_ADDR_CTRL, 8'hFF);
    wait_cyc(n + 80); do_write(PSG_ADDR_CTRL, 8'hFD);
    wait_cyc(n + 161);

    // New period landing on a tick edge: that tick still uses the old period.
    set_idle();
    do_reset(n);
    set_ch(0, n + 12, 1, 1'b0);
    w = n + 20;
    push_window(n + 1, w, "tick_wr_old");
    i0 = sqv(0, w);
    set_ch(0, w + 12, 3, i0);
    push_window(w + 1, w + 80, "tick_wr_new");
    wait_cyc(n + 4);  do_write(PSG_ADDR_CH0, 8'h3E);
    wait_cyc(n + 16); do_write(PSG_ADDR_CH0, 8'h3C);
    wait_cyc(w + 81);

    // Reset during an in-flight ch1 write with ring/disabled ctrl: everything returns to reset.
    set_idle();
    do_reset(n);
    set_ch(0, n + 12, 1, 1'b0);
    m_cl = n + 24; m_cb = 2'b10; m_ca = 2'b01;
    push_window(n + 1, n + 30, "pre_reset");
    wait_cyc(n + 4);  do_write(PSG_ADDR_CH0, 8'h3E);
    wait_cyc(n + 20); do_write(PSG_ADDR_CTRL, 8'h01);
    wait_cyc(n + 30); do_write(PSG_ADDR_CH1, 8'h3E);
    do_reset(n2);
    set_idle();
    set_ch(0, n2 + 12, 1, 1'b0);
    push_window(n2 + 1, n2 + 400, "after_reset");
    wait_cyc(n2 + 4); do_write(PSG_ADDR_CH0, 8'h3E);
    wait_cyc(n2 + 401);

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk_snd);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
